hilo_div_unit: RTL

Iterative multi-cycle divider and HI/LO register pair for the pipelined core. It sits in the EX stage beside the ALU and accepts DIV, DIVU, MTHI and MTLO. It owns the HI/LO state that the register-file view exposes. It also serves MFHI/MFLO reads and raises a pipeline stall when a read or new op arrives while a divide is in flight.

---
 rtl/hilo_pkg.sv | 17 +
 rtl/div_step.sv | 28 ++
 rtl/hilo_div_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared op codes, FSM states and default width for the HI/LO divide unit.
package hilo_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_MTHI = 2'd2;
  localparam logic [1:0] OP_MTLO = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] partial;
  logic [XLEN:0] diff;

  // partial stays below 2*divisor, so one extra bit is enough to see the borrow
  always_comb begin
    partial = {rem, quo[XLEN-1]};
    diff    = partial - {1'b0, divisor};
    if (!diff[XLEN]) begin
      rem_next = diff[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_next = partial[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_div_unit.sv
// Iterative signed/unsigned divider owning the HI/LO register pair.
// Optional DIV_ZERO_FAST_EN: zero-divisor ops skip RUN and pulse div_zero_evt.
module hilo_div_unit
  import hilo_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic [1:0]      op_code,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            rd_req,
  input  logic            rd_sel,
  output logic [XLEN-1:0] rd_data,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
`ifdef DIV_ZERO_FAST_EN
  output logic            div_zero_evt,
`endif
  output logic            stall
);

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] divisor;
  logic [XLEN-1:0] rs_orig;
  logic            sign_q;
  logic            sign_r;
  logic            div_zero;

  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;
  logic            is_div;
  logic            rs_neg;
  logic            rt_neg;
  logic [XLEN-1:0] rs_mag;
  logic [XLEN-1:0] rt_mag;

  assign is_div = (op_code == OP_DIV);
  assign rs_neg = is_div & rs_val[XLEN-1];
  assign rt_neg = is_div & rt_val[XLEN-1];
  assign rs_mag = rs_neg ? -rs_val : rs_val;
  assign rt_mag = rt_neg ? -rt_val : rt_val;

  assign rd_data = rd_sel ? lo : hi;
  assign stall   = busy & (op_valid | rd_req);

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      rs_orig  <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
      div_zero_evt <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            case (op_code)
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              default: begin
                rem      <= '0;
                quo      <= rs_mag;
                divisor  <= rt_mag;
                rs_orig  <= rs_val;
                sign_q   <= rs_neg ^ rt_neg;
                sign_r   <= rs_neg;
                div_zero <= (rt_val == '0);
                cnt      <= '0;
                busy     <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
                if (rt_val == '0) begin
                  state        <= ST_FIX;
                  div_zero_evt <= 1'b1;
                end else begin
                  state <= ST_RUN;
                end
`else
                state <= ST_RUN;
`endif
              end
            endcase
          end
        end
        ST_RUN: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          // Two's-complement fix also yields the DIV overflow result naturally
          if (div_zero) begin
            lo <= '1;
            hi <= rs_orig;
          end else begin
            lo <= sign_q ? -quo : quo;
            hi <= sign_r ? -rem : rem;
          end
          busy  <= 1'b0;
          state <= ST_IDLE;
`ifdef DIV_ZERO_FAST_EN
          div_zero_evt <= 1'b0;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
